// File: rtl/decode_queue_stage_pkg.sv
// Shared types, field-extraction macros and decoded-op bit positions for the decode stage
// and every later stage that consumes the one-hot decode vector.
`define GET_OP(i)    i[31:26]
`define GET_RS(i)    i[25:21]
`define GET_RT(i)    i[20:16]
`define GET_FUNC(i)  i[5:0]
`define GET_IMM(i)   i[15:0]
`define GET_INDEX(i) i[25:0]

package decode_queue_stage_pkg;

    localparam int DECW = 100;

    localparam int DEC_SLL     = 0;
    localparam int DEC_SRL     = 1;
    localparam int DEC_SRA     = 2;
    localparam int DEC_SLLV    = 3;
    localparam int DEC_SRLV    = 4;
    localparam int DEC_SRAV    = 5;
    localparam int DEC_JR      = 6;
    localparam int DEC_JALR    = 7;
    localparam int DEC_SYSCALL = 8;
    localparam int DEC_BREAK   = 9;
    localparam int DEC_MFHI    = 10;
    localparam int DEC_MTHI    = 11;
    localparam int DEC_MFLO    = 12;
    localparam int DEC_MTLO    = 13;
    localparam int DEC_MULT    = 14;
    localparam int DEC_MULTU   = 15;
    localparam int DEC_DIV     = 16;
    localparam int DEC_DIVU    = 17;
    localparam int DEC_ADD     = 18;
    localparam int DEC_ADDU    = 19;
    localparam int DEC_SUB     = 20;
    localparam int DEC_SUBU    = 21;
    localparam int DEC_AND     = 22;
    localparam int DEC_OR      = 23;
    localparam int DEC_XOR     = 24;
    localparam int DEC_NOR     = 25;
    localparam int DEC_SLT     = 26;
    localparam int DEC_SLTU    = 27;
    localparam int DEC_BLTZ    = 28;
    localparam int DEC_BGEZ    = 29;
    localparam int DEC_BLTZAL  = 30;
    localparam int DEC_BGEZAL  = 31;
    localparam int DEC_J       = 32;
    localparam int DEC_JAL     = 33;
    localparam int DEC_BEQ     = 34;
    localparam int DEC_BNE     = 35;
    localparam int DEC_BLEZ    = 36;
    localparam int DEC_BGTZ    = 37;
    localparam int DEC_ADDI    = 38;
    localparam int DEC_ADDIU   = 39;
    localparam int DEC_SLTI    = 40;
    localparam int DEC_SLTIU   = 41;
    localparam int DEC_ANDI    = 42;
    localparam int DEC_ORI     = 43;
    localparam int DEC_XORI    = 44;
    localparam int DEC_LUI     = 45;
    localparam int DEC_MFC0    = 46;
    localparam int DEC_MTC0    = 47;
    localparam int DEC_ERET    = 48;
    localparam int DEC_LB      = 49;
    localparam int DEC_LH      = 50;
    localparam int DEC_LW      = 51;
    localparam int DEC_LBU     = 52;
    localparam int DEC_LHU     = 53;
    localparam int DEC_SB      = 54;
    localparam int DEC_SH      = 55;
    localparam int DEC_SW      = 56;
    localparam int DEC_INVALID = 99;

    // 70-bit queue entry as pushed by fetch
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  exccode;
    } q_entry_t;

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     inst;
        logic [DECW-1:0] decoded;
        logic [31:0]     rdata1;
        logic [31:0]     rdata2;
        logic [31:0]     pc_j;
        logic [31:0]     pc_b;
        logic            exc;
        logic [4:0]      exccode;
    } slot_t;

endpackage

// File: rtl/decode_queue_stage_if.sv
// Fetch, regfile, forwarding and execute-side signals of the decode queue stage.
interface decode_queue_stage_if
    import decode_queue_stage_pkg::*;
#(
    parameter int NFWD = 3
);
    logic              flush;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [31:0]       fetch_pc;
    logic [31:0]       fetch_inst;
    logic              fetch_exc;
    logic [4:0]        fetch_exccode;
    logic [4:0]        rf_raddr1;
    logic [4:0]        rf_raddr2;
    logic [31:0]       rf_rdata1;
    logic [31:0]       rf_rdata2;
    logic [5*NFWD-1:0] fwd_addr;
    logic [32*NFWD-1:0] fwd_data;
    logic [NFWD-1:0]   fwd_ok;
    logic              ready_i;
    logic              valid_o;
    logic [31:0]       pc_o;
    logic [31:0]       inst_o;
    logic [DECW-1:0]   decoded_o;
    logic [31:0]       rdata1_o;
    logic [31:0]       rdata2_o;
    logic [31:0]       pc_j_o;
    logic [31:0]       pc_b_o;
    logic              exc_o;
    logic [4:0]        exccode_o;
    logic [31:0]       perfcnt_fwd_stall;
    logic [31:0]       perfcnt_q_full;

    modport slave (
        input  flush, fetch_valid, fetch_pc, fetch_inst, fetch_exc, fetch_exccode,
        input  rf_rdata1, rf_rdata2, fwd_addr, fwd_data, fwd_ok, ready_i,
        output fetch_ready, rf_raddr1, rf_raddr2, valid_o, pc_o, inst_o, decoded_o,
        output rdata1_o, rdata2_o, pc_j_o, pc_b_o, exc_o, exccode_o,
        output perfcnt_fwd_stall, perfcnt_q_full
    );

    modport master (
        output flush, fetch_valid, fetch_pc, fetch_inst, fetch_exc, fetch_exccode,
        output rf_rdata1, rf_rdata2, fwd_addr, fwd_data, fwd_ok, ready_i,
        input  fetch_ready, rf_raddr1, rf_raddr2, valid_o, pc_o, inst_o, decoded_o,
        input  rdata1_o, rdata2_o, pc_j_o, pc_b_o, exc_o, exccode_o,
        input  perfcnt_fwd_stall, perfcnt_q_full
    );
endinterface

// File: rtl/decode_queue_stage_inst_decoder.sv
// Combinational MIPS instruction decoder producing the one-hot op vector; anything not
// recognised sets DEC_INVALID.
module inst_decoder
    import decode_queue_stage_pkg::*;
(
    input  logic [31:0]     inst_i,
    output logic [DECW-1:0] decoded_o
);

    always_comb begin
        decoded_o = '0;
        case (`GET_OP(inst_i))
            6'h00: begin
                case (`GET_FUNC(inst_i))
                    6'h00: decoded_o[DEC_SLL]     = 1'b1;
                    6'h02: decoded_o[DEC_SRL]     = 1'b1;
                    6'h03: decoded_o[DEC_SRA]     = 1'b1;
                    6'h04: decoded_o[DEC_SLLV]    = 1'b1;
                    6'h06: decoded_o[DEC_SRLV]    = 1'b1;
                    6'h07: decoded_o[DEC_SRAV]    = 1'b1;
                    6'h08: decoded_o[DEC_JR]      = 1'b1;
                    6'h09: decoded_o[DEC_JALR]    = 1'b1;
                    6'h0C: decoded_o[DEC_SYSCALL] = 1'b1;
                    6'h0D: decoded_o[DEC_BREAK]   = 1'b1;
                    6'h10: decoded_o[DEC_MFHI]    = 1'b1;
                    6'h11: decoded_o[DEC_MTHI]    = 1'b1;
                    6'h12: decoded_o[DEC_MFLO]    = 1'b1;
                    6'h13: decoded_o[DEC_MTLO]    = 1'b1;
                    6'h18: decoded_o[DEC_MULT]    = 1'b1;
                    6'h19: decoded_o[DEC_MULTU]   = 1'b1;
                    6'h1A: decoded_o[DEC_DIV]     = 1'b1;
                    6'h1B: decoded_o[DEC_DIVU]    = 1'b1;
                    6'h20: decoded_o[DEC_ADD]     = 1'b1;
                    6'h21: decoded_o[DEC_ADDU]    = 1'b1;
                    6'h22: decoded_o[DEC_SUB]     = 1'b1;
                    6'h23: decoded_o[DEC_SUBU]    = 1'b1;
                    6'h24: decoded_o[DEC_AND]     = 1'b1;
                    6'h25: decoded_o[DEC_OR]      = 1'b1;
                    6'h26: decoded_o[DEC_XOR]     = 1'b1;
                    6'h27: decoded_o[DEC_NOR]     = 1'b1;
                    6'h2A: decoded_o[DEC_SLT]     = 1'b1;
                    6'h2B: decoded_o[DEC_SLTU]    = 1'b1;
                    default: decoded_o[DEC_INVALID] = 1'b1;
                endcase
            end
            6'h01: begin
                case (`GET_RT(inst_i))
                    5'h00: decoded_o[DEC_BLTZ]   = 1'b1;
                    5'h01: decoded_o[DEC_BGEZ]   = 1'b1;
                    5'h10: decoded_o[DEC_BLTZAL] = 1'b1;
                    5'h11: decoded_o[DEC_BGEZAL] = 1'b1;
                    default: decoded_o[DEC_INVALID] = 1'b1;
                endcase
            end
            6'h02: decoded_o[DEC_J]     = 1'b1;
            6'h03: decoded_o[DEC_JAL]   = 1'b1;
            6'h04: decoded_o[DEC_BEQ]   = 1'b1;
            6'h05: decoded_o[DEC_BNE]   = 1'b1;
            6'h06: decoded_o[DEC_BLEZ]  = 1'b1;
            6'h07: decoded_o[DEC_BGTZ]  = 1'b1;
            6'h08: decoded_o[DEC_ADDI]  = 1'b1;
            6'h09: decoded_o[DEC_ADDIU] = 1'b1;
            6'h0A: decoded_o[DEC_SLTI]  = 1'b1;
            6'h0B: decoded_o[DEC_SLTIU] = 1'b1;
            6'h0C: decoded_o[DEC_ANDI]  = 1'b1;
            6'h0D: decoded_o[DEC_ORI]   = 1'b1;
            6'h0E: decoded_o[DEC_XORI]  = 1'b1;
            6'h0F: decoded_o[DEC_LUI]   = 1'b1;
            6'h10: begin
                // COP0 sub-op lives in the rs field; ERET is the only CO-format op handled
                case (`GET_RS(inst_i))
                    5'h00: decoded_o[DEC_MFC0] = 1'b1;
                    5'h04: decoded_o[DEC_MTC0] = 1'b1;
                    5'h10: begin
                        if (`GET_FUNC(inst_i) == 6'h18) decoded_o[DEC_ERET]    = 1'b1;
                        else                            decoded_o[DEC_INVALID] = 1'b1;
                    end
                    default: decoded_o[DEC_INVALID] = 1'b1;
                endcase
            end
            6'h20: decoded_o[DEC_LB]  = 1'b1;
            6'h21: decoded_o[DEC_LH]  = 1'b1;
            6'h23: decoded_o[DEC_LW]  = 1'b1;
            6'h24: decoded_o[DEC_LBU] = 1'b1;
            6'h25: decoded_o[DEC_LHU] = 1'b1;
            6'h28: decoded_o[DEC_SB]  = 1'b1;
            6'h29: decoded_o[DEC_SH]  = 1'b1;
            6'h2B: decoded_o[DEC_SW]  = 1'b1;
            default: decoded_o[DEC_INVALID] = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage: fetch-side instruction queue, regfile read with priority forwarding,
// and a registered output slot feeding execute.
module decode_queue_stage
    import decode_queue_stage_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int NFWD   = 3
) (
    input  logic                clk,
    input  logic                reset,
    decode_queue_stage_if.slave io
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

    q_entry_t        mem_q [QDEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    slot_t           slot_q, slot_d;
    logic            valid_q, valid_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic [31:0]     full_cnt_q, full_cnt_d;

    q_entry_t        head_e, push_e;
    logic            nonempty, push, issue, slot_free, fwd_stall;
    logic            stall1, stall2;
    logic [4:0]      raddr1, raddr2;
    logic [31:0]     fdata1, fdata2, pc4;
    logic [NFWD-1:0] hit1, hit2;
    logic [DECW-1:0] dec;

    assign head_e    = mem_q[head_q];
    assign nonempty  = count_q != '0;
    assign slot_free = !valid_q || io.ready_i;
    assign push      = io.fetch_valid && io.fetch_ready;
    assign push_e    = '{pc: io.fetch_pc, inst: io.fetch_inst, exc: io.fetch_exc,
                         exccode: io.fetch_exccode};

    // Register addresses are forced to 0 on an empty queue so stale RAM never triggers a forward hit
    assign raddr1 = nonempty ? `GET_RS(head_e.inst) : 5'd0;
    assign raddr2 = nonempty ? `GET_RT(head_e.inst) : 5'd0;

    for (genvar k = 0; k < NFWD; k++) begin : g_hit
        assign hit1[k] = (io.fwd_addr[k*5 +: 5] != 5'd0) && (io.fwd_addr[k*5 +: 5] == raddr1);
        assign hit2[k] = (io.fwd_addr[k*5 +: 5] != 5'd0) && (io.fwd_addr[k*5 +: 5] == raddr2);
    end

    // Scan oldest to youngest so the lowest hitting index wins
    always_comb begin
        fdata1 = io.rf_rdata1;
        fdata2 = io.rf_rdata2;
        stall1 = 1'b0;
        stall2 = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (hit1[k]) begin
                fdata1 = io.fwd_data[k*32 +: 32];
                stall1 = !io.fwd_ok[k];
            end
            if (hit2[k]) begin
                fdata2 = io.fwd_data[k*32 +: 32];
                stall2 = !io.fwd_ok[k];
            end
        end
    end

    assign fwd_stall = stall1 || stall2;
    assign issue     = nonempty && slot_free && (!fwd_stall || head_e.exc);
    assign pc4       = head_e.pc + 32'd4;

    inst_decoder u_dec (
        .inst_i    (head_e.inst),
        .decoded_o (dec)
    );

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        slot_d      = slot_q;
        stall_cnt_d = stall_cnt_q;
        full_cnt_d  = full_cnt_q;

        if (nonempty && slot_free && fwd_stall && !head_e.exc) stall_cnt_d = stall_cnt_q + 32'd1;
        if (io.fetch_valid && !io.fetch_ready)                 full_cnt_d  = full_cnt_q + 32'd1;

        if (io.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            if (push)  tail_d = tail_q + 1'b1;
            if (issue) head_d = head_q + 1'b1;
            case ({push, issue})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (issue) begin
                valid_d        = 1'b1;
                slot_d.pc      = head_e.pc;
                slot_d.inst    = head_e.inst;
                slot_d.decoded = dec;
                slot_d.rdata1  = fdata1;
                slot_d.rdata2  = fdata2;
                slot_d.pc_j    = {pc4[31:28], `GET_INDEX(head_e.inst), 2'b00};
                slot_d.pc_b    = pc4 + {{14{head_e.inst[15]}}, `GET_IMM(head_e.inst), 2'b00};
                slot_d.exc     = head_e.exc;
                slot_d.exccode = head_e.exccode;
            end else if (io.ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            slot_q      <= '0;
            stall_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
            full_cnt_q  <= full_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !io.flush && push) mem_q[tail_q] <= push_e;
    end

    assign io.fetch_ready       = count_q != FULL;
    assign io.rf_raddr1         = raddr1;
    assign io.rf_raddr2         = raddr2;
    assign io.valid_o           = valid_q;
    assign io.pc_o              = slot_q.pc;
    assign io.inst_o            = slot_q.inst;
    assign io.decoded_o         = slot_q.decoded;
    assign io.rdata1_o          = slot_q.rdata1;
    assign io.rdata2_o          = slot_q.rdata2;
    assign io.pc_j_o            = slot_q.pc_j;
    assign io.pc_b_o            = slot_q.pc_b;
    assign io.exc_o             = slot_q.exc;
    assign io.exccode_o         = slot_q.exccode;
    assign io.perfcnt_fwd_stall = stall_cnt_q;
    assign io.perfcnt_q_full    = full_cnt_q;

endmodule
